// File: rtl/matrix_frame_loader_if.sv
// Byte-stream input and result output handshakes of the matrix frame loader.
// The loader sits on the slave side; the source/sink side uses master.
interface matrix_frame_loader_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 16
);
  logic                     in_valid;
  logic [DATA_W-1:0]        in_data;
  logic                     in_ready;
  logic                     res_valid;
  logic                     res_ready;
  logic                     res_form;
  logic signed [RES_W-1:0]  R11;
  logic signed [RES_W-1:0]  R12;
  logic signed [RES_W-1:0]  R21;
  logic signed [RES_W-1:0]  R22;

  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_form, R11, R12, R21, R22
  );

  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_form, R11, R12, R21, R22
  );
endinterface

// File: rtl/matrix_frame_loader.sv
// Collects a 9-byte cmd/A/B frame, presents it to the combinational matrix
// processor for one cycle, then holds the captured result for a downstream handshake.
//
//   state | meaning
//   LOAD  | accepting frame bytes, in_ready=1
//   EXEC  | operands stable for one cycle; processor outputs captured at its end
//   DONE  | result offered with res_valid=1 until res_ready
module matrix_frame_loader #(
  parameter int DATA_W    = 8,
  parameter int RES_W     = 16,
  parameter int FRAME_LEN = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  matrix_frame_loader_if.slave     bus,
  output logic [DATA_W-1:0]        cmd,
  output logic signed [DATA_W-1:0] A11,
  output logic signed [DATA_W-1:0] A12,
  output logic signed [DATA_W-1:0] A21,
  output logic signed [DATA_W-1:0] A22,
  output logic signed [DATA_W-1:0] B11,
  output logic signed [DATA_W-1:0] B12,
  output logic signed [DATA_W-1:0] B21,
  output logic signed [DATA_W-1:0] B22,
  input  logic                     proc_data_form,
  input  logic signed [RES_W-1:0]  proc_C11,
  input  logic signed [RES_W-1:0]  proc_C12,
  input  logic signed [RES_W-1:0]  proc_C21,
  input  logic signed [RES_W-1:0]  proc_C22,
  output logic                     busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] fld_q [FRAME_LEN];
  logic [DATA_W-1:0] fld_d [FRAME_LEN];
  logic              res_valid_q, res_valid_d;
  logic              res_form_q, res_form_d;
  logic [RES_W-1:0]  r_q [4];
  logic [RES_W-1:0]  r_d [4];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      fld_q       <= '{default: '0};
      res_valid_q <= 1'b0;
      res_form_q  <= 1'b0;
      r_q         <= '{default: '0};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fld_q       <= fld_d;
      res_valid_q <= res_valid_d;
      res_form_q  <= res_form_d;
      r_q         <= r_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fld_d       = fld_q;
    res_valid_d = res_valid_q;
    res_form_d  = res_form_q;
    r_d         = r_q;
    case (state_q)
      LOAD: begin
        if (bus.in_valid) begin
          for (int i = 0; i < FRAME_LEN; i++) begin
            if (cnt_q == 4'(i)) fld_d[i] = bus.in_data;
          end
          // >= also pulls a corrupted counter back into range
          if (cnt_q >= LAST_IDX) begin
            cnt_d   = '0;
            state_d = EXEC;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      EXEC: begin
        res_valid_d = 1'b1;
        res_form_d  = proc_data_form;
        r_d[0]      = proc_C11;
        r_d[1]      = proc_C12;
        r_d[2]      = proc_C21;
        r_d[3]      = proc_C22;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = LOAD;
        end
      end
      default: begin
        state_d     = LOAD;
        cnt_d       = '0;
        res_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == LOAD);
  assign busy          = (state_q == EXEC) || (state_q == DONE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_form  = res_form_q;
  assign bus.R11       = r_q[0];
  assign bus.R12       = r_q[1];
  assign bus.R21       = r_q[2];
  assign bus.R22       = r_q[3];

  assign cmd = fld_q[0];
  assign A11 = fld_q[1];
  assign A12 = fld_q[2];
  assign A21 = fld_q[3];
  assign A22 = fld_q[4];
  assign B11 = fld_q[5];
  assign B12 = fld_q[6];
  assign B21 = fld_q[7];
  assign B22 = fld_q[8];

endmodule

// File: tb/tb_matrix_frame_loader.sv
// Directed and randomized bench for matrix_frame_loader with a behavioural
// frame/result model compared on every falling clock edge.
module tb_matrix_frame_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_frame_loader_if #(.DATA_W(8), .RES_W(16)) bus ();

  logic [7:0]        cmd;
  logic signed [7:0] A11, A12, A21, A22, B11, B12, B21, B22;
  logic              p_form = 1'b0;
  logic signed [15:0] p_c11 = '0, p_c12 = '0, p_c21 = '0, p_c22 = '0;
  logic              busy;

  matrix_frame_loader #(.DATA_W(8), .RES_W(16), .FRAME_LEN(9)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cmd(cmd), .A11(A11), .A12(A12), .A21(A21), .A22(A22),
    .B11(B11), .B12(B12), .B21(B21), .B22(B22),
    .proc_data_form(p_form),
    .proc_C11(p_c11), .proc_C12(p_c12), .proc_C21(p_c21), .proc_C22(p_c22),
    .busy(busy)
  );

  int vectors = 0;
  int errors  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: frame bytes, how many have arrived, and where the
  // frame is in its load / execute / offer life cycle.
  logic [7:0]  m_f [9] = '{default: 8'h00};
  int          m_cnt   = 0;
  int          m_phase = 0;   // 0 loading, 1 executing, 2 offering result
  logic        m_rv    = 1'b0;
  logic        m_form  = 1'b0;
  logic [15:0] m_r [4] = '{default: 16'h0000};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_f = '{default: 8'h00}; m_cnt = 0; m_phase = 0;
      m_rv = 1'b0; m_form = 1'b0; m_r = '{default: 16'h0000};
    end else if (m_phase == 0) begin
      if (bus.in_valid) begin
        m_f[m_cnt] = bus.in_data;
        m_cnt++;
        if (m_cnt == 9) begin m_cnt = 0; m_phase = 1; end
      end
    end else if (m_phase == 1) begin
      m_rv = 1'b1; m_form = p_form;
      m_r[0] = p_c11; m_r[1] = p_c12; m_r[2] = p_c21; m_r[3] = p_c22;
      m_phase = 2;
    end else if (bus.res_ready) begin
      m_rv = 1'b0; m_phase = 0;
    end
  end

  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, m_phase == 0);
    chk("busy", busy, m_phase != 0);
    chk("res_valid", bus.res_valid, m_rv);
    chk("res_form", bus.res_form, m_form);
    chk("R11", $unsigned(bus.R11), m_r[0]);
    chk("R12", $unsigned(bus.R12), m_r[1]);
    chk("R21", $unsigned(bus.R21), m_r[2]);
    chk("R22", $unsigned(bus.R22), m_r[3]);
    chk("cmd", cmd, m_f[0]);
    chk("A11", $unsigned(A11), m_f[1]);
    chk("A12", $unsigned(A12), m_f[2]);
    chk("A21", $unsigned(A21), m_f[3]);
    chk("A22", $unsigned(A22), m_f[4]);
    chk("B11", $unsigned(B11), m_f[5]);
    chk("B12", $unsigned(B12), m_f[6]);
    chk("B21", $unsigned(B21), m_f[7]);
    chk("B22", $unsigned(B22), m_f[8]);
  end

  bit rand_mode = 1'b0;
  always @(posedge clk) begin
    if (rand_mode) begin
      #1;
      bus.res_ready = 1'($urandom_range(0, 1));
      p_form = 1'($urandom_range(0, 1));
      p_c11 = 16'($urandom); p_c12 = 16'($urandom);
      p_c21 = 16'($urandom); p_c22 = 16'($urandom);
    end
  end

  // Offers b[0..n-1]; gap_mode 0 = back-to-back, 1 = alternate, 2 = random gaps.
  // Called and returns at 1 time unit after a rising edge.
  task automatic send_bytes(input logic [7:0] b [9], input int n, input int gap_mode);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < n && guard < 300) begin
      case (gap_mode)
        0: bus.in_valid = 1'b1;
        1: bus.in_valid = (guard % 2 == 0);
        default: bus.in_valid = ($urandom_range(0, 3) != 0);
      endcase
      bus.in_data = b[idx];
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    bus.in_valid = 1'b0;
    chk("bytes_sent", idx, n);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [7:0] fr [9];
  int rv_cnt;
  int guard;

  initial begin
    bus.in_valid = 1'b0; bus.in_data = '0; bus.res_ready = 1'b0;
    cycles(2);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_cmd", cmd, 0);
    rst = 1'b0;
    cycles(1);

    // Frame 1,4,3,1,2,1,1,1,1 with result stub 7,7,3,3 and sink always ready
    p_form = 1'b1; p_c11 = 16'sd7; p_c12 = 16'sd7; p_c21 = 16'sd3; p_c22 = 16'sd3;
    bus.res_ready = 1'b1;
    fr = '{8'd1, 8'd4, 8'd3, 8'd1, 8'd2, 8'd1, 8'd1, 8'd1, 8'd1};
    send_bytes(fr, 9, 0);
    chk("t1_busy_exec", busy, 1);
    chk("t1_in_ready_exec", bus.in_ready, 0);
    chk("t1_cmd", cmd, 8'd1);
    chk("t1_A11", $unsigned(A11), 8'd4);
    chk("t1_A12", $unsigned(A12), 8'd3);
    chk("t1_A22", $unsigned(A22), 8'd2);
    chk("t1_B21", $unsigned(B21), 8'd1);
    rv_cnt = 0;
    repeat (4) begin @(negedge clk); rv_cnt += int'(bus.res_valid); end
    chk("t2_rv_cycles", rv_cnt, 1);
    chk("t2_in_ready_after", bus.in_ready, 1);
    chk("t2_R11", $unsigned(bus.R11), 16'd7);
    chk("t2_R12", $unsigned(bus.R12), 16'd7);
    chk("t2_R21", $unsigned(bus.R21), 16'd3);
    chk("t2_R22", $unsigned(bus.R22), 16'd3);
    chk("t2_form", bus.res_form, 1);
    cycles(1);

    // Determinant result held while the sink stalls; offered bytes not consumed
    p_form = 1'b0; p_c11 = -16'sd5; p_c12 = 16'sd0; p_c21 = 16'sd0; p_c22 = 16'sd0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 9; i++) fr[i] = 8'($urandom);
    send_bytes(fr, 9, 0);
    bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    rv_cnt = 0; guard = 0;
    while (rv_cnt < 6 && guard < 30) begin
      @(negedge clk);
      guard++;
      if (bus.res_valid) begin
        rv_cnt++;
        if (rv_cnt == 5) begin @(posedge clk); #1; bus.res_ready = 1'b1; end
        else if (rv_cnt == 6) bus.in_valid = 1'b0;
      end
    end
    bus.in_valid = 1'b0;
    chk("t3_rv_cycles", rv_cnt, 6);
    chk("t3_R11", $unsigned(bus.R11), 16'hFFFB);
    chk("t3_form", bus.res_form, 0);
    chk("t3_cmd_kept", cmd, fr[0]);
    @(posedge clk); #1;
    cycles(1);

    // Gapped frame with extreme signed elements
    fr = '{8'd2, 8'h80, 8'd5, 8'hF0, 8'd9, 8'd3, 8'hFE, 8'd6, 8'h7F};
    send_bytes(fr, 9, 1);
    cycles(3);
    chk("t4_A11", $unsigned(A11), 8'h80);
    chk("t4_A12", $unsigned(A12), 8'd5);
    chk("t4_B12", $unsigned(B12), 8'hFE);
    chk("t4_B22", $unsigned(B22), 8'h7F);
    chk("t4_in_ready", bus.in_ready, 1);

    // Abort a partial frame with reset, then load a fresh one
    fr = '{8'd21, 8'd22, 8'd23, 8'd24, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    send_bytes(fr, 4, 0);
    rst = 1'b1;
    #1;
    chk("t5_cmd_rst", cmd, 0);
    chk("t5_A11_rst", $unsigned(A11), 0);
    chk("t5_R11_rst", $unsigned(bus.R11), 0);
    chk("t5_rv_rst", bus.res_valid, 0);
    chk("t5_in_ready_rst", bus.in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    fr = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13};
    send_bytes(fr, 9, 0);
    cycles(3);
    chk("t5_cmd", cmd, 8'd5);
    chk("t5_A11", $unsigned(A11), 8'd6);
    chk("t5_B22", $unsigned(B22), 8'd13);

    // Reset asserted while a result is being offered
    bus.res_ready = 1'b0;
    p_form = 1'b1; p_c11 = 16'sd100; p_c12 = -16'sd1; p_c21 = 16'sd2; p_c22 = 16'sd3;
    send_bytes(fr, 9, 0);
    guard = 0;
    while (!bus.res_valid && guard < 10) begin @(negedge clk); guard++; end
    chk("t6_rv_before", bus.res_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("t6_rv_rst", bus.res_valid, 0);
    chk("t6_R11_rst", $unsigned(bus.R11), 0);
    chk("t6_R12_rst", $unsigned(bus.R12), 0);
    chk("t6_in_ready_rst", bus.in_ready, 1);
    chk("t6_busy_rst", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(1);

    // Random frames, gaps, sink stalls and processor outputs
    rand_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 9; i++) fr[i] = 8'($urandom);
      send_bytes(fr, 9, 2);
    end
    cycles(6);
    rand_mode = 1'b0;
    #1;
    bus.res_ready = 1'b1;
    cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
